// File: rtl/hs_protocol_checker.sv
// Valid/ready handshake monitor: per-channel unknown-value and stability checks with
// registered fire pulses, sticky flags, saturating count and first-error capture.
// Define HS_CHECKER_MSG_EN to report every fire with $error.
module hs_protocol_checker #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clr_err,
    input  logic [CHANNELS-1:0]       ch_valid,
    input  logic [CHANNELS-1:0]       ch_ready,
    input  logic [CHANNELS*WIDTH-1:0] ch_data,
    output logic [CHANNELS-1:0]       fire_unknown,
    output logic [CHANNELS-1:0]       fire_stable,
    output logic [CHANNELS-1:0]       err_sticky,
    output logic [CNT_W-1:0]          err_count,
    output logic                      first_err_valid,
    output logic [CH_W-1:0]           first_err_chan,
    output logic                      first_err_type
);
    localparam int SUM_W = CNT_W + $clog2(2*CHANNELS+1);

    typedef enum logic {IDLE, PEND} state_t;

    state_t           state      [CHANNELS];
    state_t           state_next [CHANNELS];
    logic [WIDTH-1:0] cap        [CHANNELS];
    logic [WIDTH-1:0] cap_next   [CHANNELS];
    logic [WIDTH-1:0] d;
    logic [CHANNELS-1:0] unk, stab, any_fire, sticky_next;
    logic [SUM_W-1:0]    n_fires, sum;
    logic [CNT_W-1:0]    cnt_base, cnt_next;
    logic                fv_next, ft_next;
    logic [CH_W-1:0]     fc_next;

    always_ff @(posedge clock) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                state[i] <= IDLE;
                cap[i]   <= '0;
            end else begin
                state[i] <= state_next[i];
                cap[i]   <= cap_next[i];
            end
        end
    end

    // Per-channel FSM and violation detection; an unknown handshake bit holds the state.
    always_comb begin
        state_next = state;
        cap_next   = cap;
        unk        = '0;
        stab       = '0;
        d          = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            d = ch_data[i*WIDTH +: WIDTH];
            if (!enable) begin
                state_next[i] = IDLE;
            end else if ($isunknown(ch_valid[i]) || $isunknown(ch_ready[i])) begin
                unk[i] = 1'b1;
            end else begin
                unk[i] = ch_valid[i] && $isunknown(d);
                case (state[i])
                    IDLE: begin
                        if (ch_valid[i] && !ch_ready[i]) begin
                            state_next[i] = PEND;
                            cap_next[i]   = d;
                        end
                    end
                    PEND: begin
                        if (!ch_valid[i]) begin
                            stab[i]       = 1'b1;
                            state_next[i] = IDLE;
                        end else begin
                            stab[i] = (d !== cap[i]);
                            if (ch_ready[i]) state_next[i] = IDLE;
                            else             cap_next[i]   = d;
                        end
                    end
                    default: state_next[i] = IDLE;
                endcase
            end
        end
    end

    // clr_err wipes the old record first so same-cycle violations are still captured.
    always_comb begin
        n_fires = '0;
        for (int i = 0; i < CHANNELS; i++)
            n_fires = n_fires + SUM_W'(unk[i]) + SUM_W'(stab[i]);
        cnt_base    = clr_err ? '0 : err_count;
        sum         = SUM_W'(cnt_base) + n_fires;
        cnt_next    = (sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        any_fire    = unk | stab;
        sticky_next = (clr_err ? '0 : err_sticky) | any_fire;
        fv_next     = clr_err ? 1'b0 : first_err_valid;
        fc_next     = clr_err ? '0   : first_err_chan;
        ft_next     = clr_err ? 1'b0 : first_err_type;
        if (!fv_next && (|any_fire)) begin
            fv_next = 1'b1;
            for (int i = CHANNELS-1; i >= 0; i--) begin
                if (any_fire[i]) begin
                    fc_next = CH_W'(i);
                    ft_next = ~unk[i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fire_unknown    <= '0;
            fire_stable     <= '0;
            err_sticky      <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_chan  <= '0;
            first_err_type  <= 1'b0;
        end else begin
            fire_unknown    <= unk;
            fire_stable     <= stab;
            err_sticky      <= sticky_next;
            err_count       <= cnt_next;
            first_err_valid <= fv_next;
            first_err_chan  <= fc_next;
            first_err_type  <= ft_next;
        end
    end

`ifdef HS_CHECKER_MSG_EN
    always_ff @(posedge clock) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (fire_unknown[i]) $error("%0t: channel %0d unknown-value violation", $time, i);
            if (fire_stable[i])  $error("%0t: channel %0d stability violation", $time, i);
        end
    end
`else
    // silent build: no reporting logic
`endif

endmodule

// File: tb/tb_hs_protocol_checker.sv
// Bench for hs_protocol_checker: table vectors through a latency-1 scoreboard, plus a
// reset-in-PEND sequence and X/Z cases that only run on a four-state simulator.
module tb_hs_protocol_checker;
    localparam int CH = 4;
    localparam int W  = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset, enable, clr_err;
    logic [CH-1:0]   ch_valid, ch_ready;
    logic [CH*W-1:0] ch_data;
    logic [CH-1:0]   fire_unknown, fire_stable, err_sticky;
    logic [7:0]      err_count;
    logic            first_err_valid, first_err_type;
    logic [1:0]      first_err_chan;
    logic [CH-1:0]   s_fu, s_fs, s_sticky;
    logic [1:0]      s_count;
    logic            s_fv, s_ft;
    logic [1:0]      s_fc;

    hs_protocol_checker #(.WIDTH(W), .CHANNELS(CH), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clr_err(clr_err),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
        .fire_unknown(fire_unknown), .fire_stable(fire_stable), .err_sticky(err_sticky),
        .err_count(err_count), .first_err_valid(first_err_valid),
        .first_err_chan(first_err_chan), .first_err_type(first_err_type)
    );

    // Narrow counter copy on the same stimulus to exercise saturation.
    hs_protocol_checker #(.WIDTH(W), .CHANNELS(CH), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .enable(enable), .clr_err(clr_err),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
        .fire_unknown(s_fu), .fire_stable(s_fs), .err_sticky(s_sticky),
        .err_count(s_count), .first_err_valid(s_fv),
        .first_err_chan(s_fc), .first_err_type(s_ft)
    );

    typedef struct {
        logic        rst, en, clr;
        logic [3:0]  v, r;
        logic [31:0] d;
        logic [3:0]  fu, fs, stk;
        logic [7:0]  cnt;
        logic        fv;
        logic [1:0]  fc;
        logic        ft;
    } vec_t;

    vec_t tbl[$];
    vec_t unk_tbl[$];
    vec_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   vidx   = 0;
    logic probe;
    logic four_state;

    function automatic vec_t mk(input int rst, en, clr, input logic [3:0] v, r,
                                input logic [31:0] d, input int fu, fs, stk, cnt,
                                input int fv, fc, ft);
        vec_t m;
        m.rst = 1'(rst); m.en = 1'(en); m.clr = 1'(clr);
        m.v = v; m.r = r; m.d = d;
        m.fu = 4'(fu); m.fs = 4'(fs); m.stk = 4'(stk); m.cnt = 8'(cnt);
        m.fv = 1'(fv); m.fc = 2'(fc); m.ft = 1'(ft);
        return m;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        vec_t e;
        @(negedge clock);
        reset = t.rst; enable = t.en; clr_err = t.clr;
        ch_valid = t.v; ch_ready = t.r; ch_data = t.d;
        sb.push_back(t);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk("fire_unknown",    vidx, 32'(fire_unknown),    32'(e.fu));
        chk("fire_stable",     vidx, 32'(fire_stable),     32'(e.fs));
        chk("err_sticky",      vidx, 32'(err_sticky),      32'(e.stk));
        chk("err_count",       vidx, 32'(err_count),       32'(e.cnt));
        chk("first_err_valid", vidx, 32'(first_err_valid), 32'(e.fv));
        chk("first_err_chan",  vidx, 32'(first_err_chan),  32'(e.fc));
        chk("first_err_type",  vidx, 32'(first_err_type),  32'(e.ft));
        chk("sat_err_count",   vidx, 32'(s_count), (e.cnt > 8'd3) ? 32'd3 : 32'(e.cnt));
        chk("sat_err_sticky",  vidx, 32'(s_sticky),        32'(e.stk));
        vidx++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; clr_err = 1'b0;
        ch_valid = '0; ch_ready = '0; ch_data = '0;
        probe = 1'bx;
        four_state = $isunknown(probe);

        //            rst en clr v        r        d              fu       fs       stk      cnt fv fc ft
        tbl.push_back(mk(1, 0, 0, 4'h0,    4'h0,    32'h0,         0,       0,       0,       0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 4'hF,    4'h0,    32'h0,         0,       0,       0,       0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0,    4'h0,    32'h0,         0,       0,       0,       0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0100, 4'h0,    32'h005A0000,  0,       0,       0,       0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0100, 4'h0,    32'h005B0000,  0,       4'b0100, 4'b0100, 1, 1, 2, 1));
        tbl.push_back(mk(0, 1, 0, 4'b0100, 4'b0100, 32'h005B0000,  0,       0,       4'b0100, 1, 1, 2, 1));
        tbl.push_back(mk(0, 1, 0, 4'b0011, 4'h0,    32'h00002211,  0,       0,       4'b0100, 1, 1, 2, 1));
        tbl.push_back(mk(0, 1, 0, 4'h0,    4'h0,    32'h0,         0,       4'b0011, 4'b0111, 3, 1, 2, 1));
        tbl.push_back(mk(0, 1, 0, 4'b1000, 4'h0,    32'h33000000,  0,       0,       4'b0111, 3, 1, 2, 1));
        tbl.push_back(mk(0, 0, 0, 4'h0,    4'h0,    32'h0,         0,       0,       4'b0111, 3, 1, 2, 1));
        tbl.push_back(mk(0, 1, 0, 4'h0,    4'h0,    32'h0,         0,       0,       4'b0111, 3, 1, 2, 1));
        tbl.push_back(mk(0, 1, 1, 4'h0,    4'h0,    32'h0,         0,       0,       0,       0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 4'h0,    32'h00001000,  0,       0,       0,       0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0,    4'h0,    32'h0,         0,       4'b0010, 4'b0010, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'b0001, 4'h0,    32'h000000AA,  0,       0,       4'b0010, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 4'b0001, 4'h0,    32'h000000AB,  0,       4'b0001, 4'b0001, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'b0001, 4'b0001, 32'h000000AB,  0,       0,       4'b0001, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 4'h0,    4'h0,    32'h0,         0,       0,       0,       0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b1010, 4'h0,    32'h03000100,  0,       0,       0,       0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0,    4'h0,    32'h0,         0,       4'b1010, 4'b1010, 2, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF,    4'hF,    32'h12345678,  0,       0,       4'b1010, 2, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'h0,    4'hF,    32'h0,         0,       0,       4'b1010, 2, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF,    4'h0,    32'h01010101,  0,       0,       4'b1010, 2, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'h0,    4'h0,    32'h0,         0,       4'b1111, 4'b1111, 6, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'b0001, 4'h0,    32'h0000000F,  0,       0,       4'b1111, 6, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'b0001, 4'b0001, 32'h000000F0,  0,       4'b0001, 4'b1111, 7, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'h0,    4'h0,    32'h0,         0,       0,       4'b1111, 7, 1, 1, 1));

        unk_tbl.push_back(mk(0, 1, 0, 4'b0001, 4'b0001, {24'h0, 8'hxx}, 4'b0001, 0,       4'b0001, 1, 1, 0, 0));
        unk_tbl.push_back(mk(0, 1, 1, 4'b10x0, 4'b1000, {8'hxx, 24'h0}, 4'b1010, 0,       4'b1010, 2, 1, 1, 0));
        unk_tbl.push_back(mk(0, 1, 1, 4'b0001, 4'h0,    32'h00000012,   0,       0,       0,       0, 0, 0, 0));
        unk_tbl.push_back(mk(0, 1, 0, 4'b0001, 4'h0,    {24'h0, 8'hxx}, 4'b0001, 4'b0001, 4'b0001, 2, 1, 0, 0));
        unk_tbl.push_back(mk(0, 0, 0, 4'b000x, 4'h0,    32'h0,          0,       0,       4'b0001, 2, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Reset lands while ch2 waits in PEND, together with a valid drop and clr_err.
        apply(mk(0, 1, 0, 4'b0100, 4'h0, 32'h005A0000, 0, 0, 4'b1111, 7, 1, 1, 1));
        apply(mk(1, 1, 1, 4'h0,    4'h0, 32'h0,        0, 0, 0,       0, 0, 0, 0));
        apply(mk(0, 1, 0, 4'h0,    4'h0, 32'h0,        0, 0, 0,       0, 0, 0, 0));

        if (four_state)
            for (int i = 0; i < unk_tbl.size(); i++) apply(unk_tbl[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hs_protocol_checker.md
HS_PROTOCOL_CHECKER -- requirements
Module: hs_protocol_checker

Interface
REQ-001 SHALL have parameters: WIDTH, default 8, data bits per channel; CHANNELS, default 4, number of monitored channels; CNT_W, default 8, error counter width.
REQ-002 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: enable  in  1  checking gate; 0 suppresses all new fires.
REQ-005 SHALL have ports: clr_err  in  1  clears sticky flags, counter and first-error capture.
REQ-006 SHALL have ports: ch_valid  in  CHANNELS  per-channel valid.
REQ-007 SHALL have ports: ch_ready  in  CHANNELS  per-channel ready.
REQ-008 SHALL have ports: ch_data  in  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have ports: fire_unknown  out  CHANNELS  one-cycle pulse, unknown-value violation.
REQ-010 SHALL have ports: fire_stable  out  CHANNELS  one-cycle pulse, handshake-stability violation.
REQ-011 SHALL have ports: err_sticky  out  CHANNELS  per-channel latched error.
REQ-012 SHALL have ports: err_count  out  CNT_W  saturating total violation count.
REQ-013 SHALL have ports: first_err_valid  out  1, first_err_chan  out  max(1,$clog2(CHANNELS)), first_err_type  out  1 (0 unknown, 1 stability).

Function
REQ-014 SHALL flag an unknown violation on channel i when enable=1 and ch_valid[i] or ch_ready[i] is X/Z, or ch_valid[i]=1 and any ch_data bit of channel i is X/Z.
REQ-015 SHALL keep a per-channel 2-state FSM, IDLE and PEND: IDLE->PEND when valid=1 and ready=0 (capture data); PEND->IDLE when valid=1 and ready=1; PEND->PEND otherwise.
REQ-016 SHALL flag a stability violation in PEND when valid drops to 0, or when valid=1 and data differs from the captured value; the FSM then returns to IDLE, or re-captures data if valid=1 and ready=0.
REQ-017 SHALL register fires: a violation sampled at edge N drives the pulse during cycle N+1 (latency 1).
REQ-018 SHALL set err_sticky[i] on any fire of channel i and hold it until clr_err or reset.
REQ-019 SHALL add the number of fires asserted in a cycle, counting both types across all channels, to err_count, saturating at 2^CNT_W-1 with no wrap.
REQ-020 SHALL capture the first violation after reset or clr_err: lowest channel index wins; unknown beats stability on the same channel; capture is frozen while first_err_valid=1.
REQ-021 SHALL, when clr_err coincides with new violations, clear the old state and then record the new violations, so the new counts, sticky bits and first capture are all visible.
REQ-022 SHALL, with enable=0, emit no fires and force all FSMs to IDLE; sticky flags, count and capture are held.
REQ-023 SHALL treat an X/Z valid as unknown only and leave the FSM state unchanged that cycle.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, zero fire_unknown, fire_stable, err_sticky, err_count, first_err_valid, first_err_chan and first_err_type, and set all FSMs to IDLE.
REQ-025 SHALL give reset priority over clr_err, enable and any violation, including a reset asserted mid-handshake in PEND.

Configuration
REQ-026 SHALL, with HS_CHECKER_MSG_EN defined, issue $error per fire, giving time, channel and type; without it, print nothing. Output behaviour is identical in both builds.

Verification
REQ-027 CHANNELS=4: ch0 valid=1, data=8'hxx -> fire_unknown=4'b0001 next cycle; err_count=1; first_err_chan=0, first_err_type=0.
REQ-028 ch2 valid=1, ready=0, data=8'h5A, then data=8'h5B with valid=1 -> fire_stable[2] pulse; err_sticky=4'b0100.
REQ-029 Unknowns on ch1 and ch3 in one cycle -> err_count +2; first_err_chan=1.
REQ-030 CNT_W=2, 5 violations -> err_count saturates at 3.
REQ-031 clr_err coincident with a ch0 stability fire -> err_count=1, first_err_valid=1, err_sticky=4'b0001.
REQ-032 reset asserted in PEND, then valid=0 -> no fire_stable; all outputs 0.
